instruction_fetch_unit: RTL and testbench

//  Front end of the core. Owns the PC and issues word fetches to instruction memory.

---
 rtl/instruction_fetch_unit_pkg.sv | 34 +++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/instruction_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and the prefetch entry layout for the instruction fetch unit.
// Type codes, RV32 opcodes, the NOP word and the default reset vector live here.
package instruction_fetch_unit_pkg;

    localparam logic [2:0] I_TYPE = 3'd0;
    localparam logic [2:0] S_TYPE = 3'd1;
    localparam logic [2:0] B_TYPE = 3'd2;
    localparam logic [2:0] U_TYPE = 3'd3;
    localparam logic [2:0] J_TYPE = 3'd4;
    localparam logic [2:0] R_TYPE = 3'd5;
    localparam logic [2:0] X_TYPE = 3'd7;

    localparam logic [6:0] OPCODE_OP       = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
    localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
    localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL      = 7'b1101111;

    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;
    localparam logic [31:0] RESET_VECTOR    = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with occupancy count and flush; head data is read straight
// from storage so the output is always a registered value.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Core front end: owns the PC, issues word fetches, buffers returned words in order
// and presents the predecoded head entry to decode; redirects flush and drop stale data.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_VECTOR,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic [2:0]  if_instruction_type,
    output logic        if_illegal
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]        pc_next_q, pc_next_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic [CNT_W-1:0]   pend_count;
    logic [CNT_W-1:0]   pf_count;
    logic [31:0]        pend_head_pc;
    logic [ENTRY_W-1:0] pf_head_raw;
    fetch_entry_t       pf_head;
    fetch_entry_t       pf_push_entry;
    logic               pf_empty;
    logic               pf_pop;
    logic               pf_push;
    logic               pend_pop;
    logic               req_fire;
    logic [SUM_W-1:0]   slots_used;

    assign pf_head = pf_head_raw;

    // Credit check: in-flight plus buffered words never exceed FIFO_DEPTH; a same-cycle
    // pop frees its slot so a zero-wait memory sustains one fetch per cycle.
    always_comb begin
        pf_empty       = (pf_count == '0);
        pf_pop         = !pf_empty && if_ready && !redirect_valid;
        slots_used     = SUM_W'(pend_count) + SUM_W'(pf_count) - SUM_W'(pf_pop);
        imem_req_valid = !reset && !redirect_valid && (slots_used < SUM_W'(FIFO_DEPTH));
        imem_req_addr  = pc_next_q;
        req_fire       = imem_req_valid && imem_req_ready;
        pend_pop       = imem_rsp_valid && (pend_count != '0);
        pf_push        = pend_pop && !redirect_valid && (drop_q == '0);
        pf_push_entry  = '{pc: pend_head_pc, instr: imem_rsp_data};
    end

    // A redirect counts every request still in flight as stale, minus one answered now.
    always_comb begin
        pc_next_d = pc_next_q;
        drop_d    = drop_q;
        if (redirect_valid) begin
            pc_next_d = redirect_pc & 32'hFFFF_FFFC;
            drop_d    = pend_count - CNT_W'(pend_pop);
        end else begin
            if (req_fire) begin
                pc_next_d = pc_next_q + 32'd4;
            end
            if (pend_pop && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_next_q <= RESET_PC & 32'hFFFF_FFFC;
            drop_q    <= '0;
        end else begin
            pc_next_q <= pc_next_d;
            drop_q    <= drop_d;
        end
    end

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_pending_pc (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (pc_next_q),
        .pop       (pend_pop),
        .head_data (pend_head_pc),
        .count     (pend_count)
    );

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_prefetch (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (pf_push),
        .push_data (pf_push_entry),
        .pop       (pf_pop),
        .head_data (pf_head_raw),
        .count     (pf_count)
    );

    // An empty FIFO presents a NOP so the immediate generator always sees a legal word.
    always_comb begin
        if_valid       = !pf_empty && !redirect_valid;
        if_pc          = 32'h0;
        if_instruction = NOP_INSTRUCTION;
        if (!pf_empty) begin
            if_pc          = pf_head.pc;
            if_instruction = pf_head.instr;
        end
    end

    always_comb begin
        if_instruction_type = X_TYPE;
        case (if_instruction[6:0])
            OPCODE_OP:                  if_instruction_type = R_TYPE;
            OPCODE_OP_IMM, OPCODE_LOAD,
            OPCODE_JALR, OPCODE_SYSTEM: if_instruction_type = I_TYPE;
            OPCODE_STORE:               if_instruction_type = S_TYPE;
            OPCODE_BRANCH:              if_instruction_type = B_TYPE;
            OPCODE_LUI, OPCODE_AUIPC:   if_instruction_type = U_TYPE;
            OPCODE_JAL:                 if_instruction_type = J_TYPE;
            default:                    if_instruction_type = X_TYPE;
        endcase
        if_illegal = (if_instruction_type == X_TYPE);
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: zero-wait memory model feeding a scoreboard of
// expected {pc, word} pairs, plus directed scenario tasks.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid, if_ready, if_illegal;
    logic [31:0] if_pc, if_instruction;
    logic [2:0]  if_instruction_type;

    logic        req_valid_w, rsp_valid_w, if_valid_w, if_illegal_w;
    logic [31:0] req_addr_w, rsp_data_w, if_pc_w, if_instr_w;
    logic [2:0]  if_type_w;
    logic        fire_w = 1'b0;

    int n_run  = 0;
    int n_fail = 0;

    logic [31:0] mem_pend [$];
    logic [63:0] exp_q [$];
    logic        mem_hold = 1'b0;
    logic [63:0] sb_e;
    logic [31:0] sb_a;
    logic [2:0]  sb_t;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_instruction(if_instruction),
        .if_instruction_type(if_instruction_type), .if_illegal(if_illegal)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req_valid(req_valid_w), .imem_req_ready(1'b1),
        .imem_req_addr(req_addr_w), .imem_rsp_valid(rsp_valid_w),
        .imem_rsp_data(rsp_data_w), .redirect_valid(1'b0),
        .redirect_pc(32'h0), .if_valid(if_valid_w), .if_ready(1'b1),
        .if_pc(if_pc_w), .if_instruction(if_instr_w),
        .if_instruction_type(if_type_w), .if_illegal(if_illegal_w)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h300: return 32'h0050_0093;
            32'h304: return 32'h0011_2023;
            32'h308: return 32'hFE00_0EE3;
            32'h30C: return 32'h0000_12B7;
            32'h310: return 32'h0040_006F;
            32'h314: return 32'hFFFF_FFFF;
            default: return {a[26:2], 7'b0010011};
        endcase
    endfunction

    function automatic logic [2:0] exp_type(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        if (op == 7'h33) return R_TYPE;
        if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73) return I_TYPE;
        if (op == 7'h23) return S_TYPE;
        if (op == 7'h63) return B_TYPE;
        if (op == 7'h37 || op == 7'h17) return U_TYPE;
        if (op == 7'h6F) return J_TYPE;
        return X_TYPE;
    endfunction

    // Memory model: answers one cycle after accept unless held; scoreboard checks deliveries.
    always begin
        @(negedge clk);
        if (reset) begin
            mem_pend.delete();
            exp_q.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end else if (!mem_hold && mem_pend.size() > 0) begin
            sb_a           = mem_pend.pop_front();
            imem_rsp_data  = mem_word(sb_a);
            imem_rsp_valid = 1'b1;
        end else begin
            imem_rsp_valid = 1'b0;
        end
        #4;
        if (!reset) begin
            if (redirect_valid) begin
                exp_q.delete();
            end else if (if_valid && if_ready) begin
                n_run++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got pc=%h instr=%h, required no delivery", if_pc, if_instruction);
                end else begin
                    sb_e = exp_q.pop_front();
                    sb_t = exp_type(sb_e[31:0]);
                    if ({if_pc, if_instruction} !== sb_e || if_instruction_type !== sb_t
                        || if_illegal !== (sb_t == X_TYPE)) begin
                        n_fail++;
                        $display("FAIL sb_entry: got pc=%h instr=%h type=%0d ill=%b, required pc=%h instr=%h type=%0d",
                                 if_pc, if_instruction, if_instruction_type, if_illegal, sb_e[63:32], sb_e[31:0], sb_t);
                    end
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                mem_pend.push_back(imem_req_addr);
                exp_q.push_back({imem_req_addr, mem_word(imem_req_addr)});
            end
        end
    end

    // Zero-wait memory for the wrap-around instance.
    always begin
        @(negedge clk);
        rsp_valid_w = reset ? 1'b0 : fire_w;
        rsp_data_w  = NOP_INSTRUCTION;
        #4;
        fire_w = !reset && req_valid_w;
    end

    task automatic apply_reset(input logic rdy);
        @(negedge clk);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = rdy;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        #4;
        n_run++;
        if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_instruction !== 32'h0000_0013
            || if_instruction_type !== I_TYPE || if_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%b v=%b pc=%h instr=%h type=%0d ill=%b, required 0 0 0 00000013 %0d 0",
                     imem_req_valid, if_valid, if_pc, if_instruction, if_instruction_type, if_illegal, I_TYPE);
        end
    endtask

    task automatic test_stream;
        apply_reset(1'b1);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            #4;
            n_run++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL stream_req[%0d]: got v=%b addr=%h, required 1 %h", i, imem_req_valid, imem_req_addr, 32'(4 * i));
            end
            n_run++;
            if (if_valid !== (i >= 2) || (i >= 2 && if_pc !== 32'(4 * (i - 2)))) begin
                n_fail++;
                $display("FAIL stream_if[%0d]: got v=%b pc=%h, required v=%b pc=%h", i, if_valid, if_pc, i >= 2, 32'(4 * (i - 2)));
            end
        end
    endtask

    task automatic test_backpressure;
        int accepts;
        logic [31:0] got [$];
        logic ok;
        accepts = 0;
        apply_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            #4;
            if (imem_req_valid && imem_req_ready) accepts++;
        end
        n_run++;
        if (accepts != 2 || imem_req_valid !== 1'b0 || if_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_stall: got accepts=%0d req=%b v=%b, required 2 0 1", accepts, imem_req_valid, if_valid);
        end
        @(negedge clk);
        if_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            #4;
            if (if_valid && if_ready) got.push_back(if_pc);
        end
        ok = (got.size() >= 10);
        for (int k = 0; k < got.size(); k++) if (got[k] !== 32'(4 * k)) ok = 1'b0;
        n_run++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_resume_order: got %0d words first pc=%h, required >=10 words pcs 0,4,8,...",
                     got.size(), got.size() > 0 ? got[0] : 32'hX);
        end
    endtask

    task automatic test_redirect_outstanding;
        logic        seen_req, seen_if;
        logic [31:0] first_req, first_pc;
        seen_req = 1'b0;
        seen_if  = 1'b0;
        first_req = 32'h0;
        first_pc  = 32'h0;
        mem_hold = 1'b1;
        repeat (4) begin @(negedge clk); #4; end
        n_run++;
        if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_two_outstanding: got req=%b v=%b, required 0 0", imem_req_valid, if_valid);
        end
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        #4;
        n_run++;
        if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_cycle: got req=%b v=%b, required 0 0", imem_req_valid, if_valid);
        end
        mem_hold = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int i = 0; i < 20 && !seen_if; i++) begin
            if (i > 0) @(negedge clk);
            #4;
            if (!seen_req && imem_req_valid && imem_req_ready) begin seen_req = 1'b1; first_req = imem_req_addr; end
            if (if_valid && if_ready) begin seen_if = 1'b1; first_pc = if_pc; end
        end
        n_run++;
        if (!seen_if || !seen_req || first_req !== 32'h100 || first_pc !== 32'h100) begin
            n_fail++;
            $display("FAIL rd_target: got seen=%b/%b req=%h pc=%h, required 1/1 00000100 00000100",
                     seen_req, seen_if, first_req, first_pc);
        end
    endtask

    task automatic test_redirect_collision;
        logic        seen_if;
        logic [31:0] first_pc;
        seen_if  = 1'b0;
        first_pc = 32'h0;
        repeat (6) begin @(negedge clk); #4; end
        n_run++;
        if (if_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rc_pre_valid: got v=%b, required 1", if_valid);
        end
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        #4;
        n_run++;
        if (if_valid !== 1'b0 || imem_rsp_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rc_cycle: got v=%b rsp=%b req=%b, required 0 1 0", if_valid, imem_rsp_valid, imem_req_valid);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int i = 0; i < 20 && !seen_if; i++) begin
            if (i > 0) @(negedge clk);
            #4;
            if (if_valid && if_ready) begin seen_if = 1'b1; first_pc = if_pc; end
        end
        n_run++;
        if (!seen_if || first_pc !== 32'h200) begin
            n_fail++;
            $display("FAIL rc_target: got seen=%b pc=%h, required 1 00000200", seen_if, first_pc);
        end
    endtask

    task automatic test_predecode_async_reset;
        logic [2:0] want [6];
        int seen;
        int idx;
        want = '{I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE, X_TYPE};
        seen = 0;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int i = 0; i < 30 && seen < 6; i++) begin
            if (i > 0) @(negedge clk);
            #4;
            if (if_valid && if_ready && if_pc >= 32'h300 && if_pc < 32'h318) begin
                idx = int'((if_pc - 32'h300) >> 2);
                seen++;
                n_run++;
                if (if_instruction_type !== want[idx] || if_illegal !== (idx == 5)) begin
                    n_fail++;
                    $display("FAIL pd_type[%0d]: got type=%0d ill=%b, required type=%0d ill=%b",
                             idx, if_instruction_type, if_illegal, want[idx], idx == 5);
                end
            end
        end
        n_run++;
        if (seen != 6) begin
            n_fail++;
            $display("FAIL pd_count: got %0d words, required 6", seen);
        end
        @(negedge clk);
        #4;
        n_run++;
        if (if_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_pre_valid: got v=%b, required 1", if_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        n_run++;
        if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_instruction !== 32'h0000_0013
            || if_instruction_type !== I_TYPE || if_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_outputs: got req=%b v=%b pc=%h instr=%h type=%0d ill=%b, required 0 0 0 00000013 %0d 0",
                     imem_req_valid, if_valid, if_pc, if_instruction, if_instruction_type, if_illegal, I_TYPE);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wrap;
        logic [31:0] want [3];
        want = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        apply_reset(1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #4;
            n_run++;
            if (req_valid_w !== 1'b1 || req_addr_w !== want[i]) begin
                n_fail++;
                $display("FAIL wrap_addr[%0d]: got v=%b addr=%h, required 1 %h", i, req_valid_w, req_addr_w, want[i]);
            end
        end
        n_run++;
        if (if_valid_w !== 1'b1 || if_pc_w !== 32'hFFFF_FFF8) begin
            n_fail++;
            $display("FAIL wrap_if: got v=%b pc=%h, required 1 fffffff8", if_valid_w, if_pc_w);
        end
    endtask

    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_collision();
        test_predecode_async_reset();
        test_wrap();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
